// File: rtl/mxu_pe_simd_pkg.sv
// rtl/mxu_pe_simd_pkg.sv - precision codes and lane-isolated arithmetic helpers for the MXU PE
package mxu_pe_simd_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 2;

    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_8  = 2'd0;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_16 = 2'd1;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_32 = 2'd2;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_64 = 2'd3;

    // Lane width in bits for a precision code: 8, 16, 32 or 64.
    function automatic int lane_width(input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        return 8 << dt;
    endfunction

    // One bit set at the most significant position of every lane.
    function automatic logic [63:0] lane_msb_mask(input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i++) begin
            m[i] = (((i + 1) % lane_width(dt)) == 0);
        end
        return m;
    endfunction

    // Lane-wise add modulo 2^L. Lane MSBs are excluded from the wide add so
    // no carry can cross a lane boundary, then restored with an XOR.
    function automatic logic [63:0] simd_add(input logic [63:0] a,
                                             input logic [63:0] b,
                                             input logic [LOG_ALLOWED_PRECISIONS-1:0] dt);
        logic [63:0] m;
        m = lane_msb_mask(dt);
        return ((a & ~m) + (b & ~m)) ^ ((a ^ b) & m);
    endfunction

endpackage

// File: rtl/mxu_pe_simd_lane_mac.sv
// rtl/mxu_pe_simd_lane_mac.sv - lane-masked SIMD multiplier, products truncated to lane width
module simd_lane_mac
    import mxu_pe_simd_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] w,
    input  logic [1:0]  data_type,
    output logic [63:0] product
);

    logic [63:0] p8;
    logic [63:0] p16;
    logic [63:0] p32;
    logic [63:0] p64;

    // Truncated two's-complement products equal truncated unsigned products,
    // so every lane can use a plain unsigned multiply of lane width.
    always_comb begin
        p8 = '0;
        for (int i = 0; i < 8; i++) begin
            p8[8*i +: 8] = a[8*i +: 8] * w[8*i +: 8];
        end
    end

    // 16-bit lane products.
    always_comb begin
        p16 = '0;
        for (int i = 0; i < 4; i++) begin
            p16[16*i +: 16] = a[16*i +: 16] * w[16*i +: 16];
        end
    end

    // 32-bit lane products.
    always_comb begin
        p32 = '0;
        for (int i = 0; i < 2; i++) begin
            p32[32*i +: 32] = a[32*i +: 32] * w[32*i +: 32];
        end
    end

    assign p64 = a * w;

    // Select the product set matching the operation's precision tag.
    always_comb begin
        product = p64;
        case (data_type)
            PREC_8:  product = p8;
            PREC_16: product = p16;
            PREC_32: product = p32;
            default: product = p64;
        endcase
    end

endmodule

// File: rtl/register.sv
// rtl/register.sv - single pipeline register cell with enable and synchronous clear
module register #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce,
    input  logic             sclr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Load on enable; clear takes priority over load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (ce) begin
            q <= sclr ? '0 : d;
        end
    end

endmodule

// File: rtl/mxu_pe_simd.sv
// rtl/mxu_pe_simd.sv - systolic SIMD MAC processing element with double-buffered weights
module mxu_pe_simd
    import mxu_pe_simd_pkg::*;
#(
    parameter int    BIT_WIDTH  = 64,
    parameter int    FWD_DEPTH  = 2,
    parameter string USE_FABRIC = "NO"
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ce,
    input  logic                 sclr,
    input  logic [1:0]           data_type,
    input  logic                 data_valid_in,
    input  logic [BIT_WIDTH-1:0] data_input,
    input  logic [BIT_WIDTH-1:0] res_mac_p,
    input  logic [BIT_WIDTH-1:0] weight_in,
    input  logic                 weight_shift,
    input  logic                 weight_swap,
    output logic [BIT_WIDTH-1:0] weight_out,
    output logic [BIT_WIDTH-1:0] res_mac_n,
    output logic                 res_valid,
    output logic [BIT_WIDTH-1:0] data_input_next_row,
    output logic                 data_valid_next_row
);

    logic [BIT_WIDTH-1:0] shadow_w;
    logic [BIT_WIDTH-1:0] active_w;
    logic [BIT_WIDTH-1:0] product;

    logic [BIT_WIDTH-1:0] s1_prod;
    logic [BIT_WIDTH-1:0] s1_psum;
    logic [1:0]           s1_tag;
    logic                 s1_valid;

    logic [BIT_WIDTH-1:0] s2_res;
    logic                 s2_valid;

    // Multiplier mapping is a physical choice only; behaviour is identical.
    generate
        if (USE_FABRIC == "YES") begin : g_fabric_mul
            (* use_dsp = "no" *)
            simd_lane_mac u_mac (
                .a         (data_input),
                .w         (active_w),
                .data_type (data_type),
                .product   (product)
            );
        end else begin : g_dsp_mul
            (* use_dsp = "yes" *)
            simd_lane_mac u_mac (
                .a         (data_input),
                .w         (active_w),
                .data_type (data_type),
                .product   (product)
            );
        end
    endgenerate

    // Weight double buffer: swap copies the pre-edge shadow, so a same-cycle
    // shift and swap moves the old shadow forward while loading the new one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_w <= '0;
            active_w <= '0;
        end else if (ce) begin
            if (sclr) begin
                shadow_w <= '0;
                active_w <= '0;
            end else begin
                if (weight_shift) shadow_w <= weight_in;
                if (weight_swap)  active_w <= shadow_w;
            end
        end
    end

    // Stage 1: capture lane products, partial sum and the precision tag that
    // travels with this operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_prod  <= '0;
            s1_psum  <= '0;
            s1_tag   <= '0;
            s1_valid <= 1'b0;
        end else if (ce) begin
            if (sclr) begin
                s1_prod  <= '0;
                s1_psum  <= '0;
                s1_tag   <= '0;
                s1_valid <= 1'b0;
            end else begin
                s1_prod  <= product;
                s1_psum  <= res_mac_p;
                s1_tag   <= data_type;
                s1_valid <= data_valid_in;
            end
        end
    end

    // Stage 2: lane-isolated accumulate using the tag captured in stage 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_res   <= '0;
            s2_valid <= 1'b0;
        end else if (ce) begin
            if (sclr) begin
                s2_res   <= '0;
                s2_valid <= 1'b0;
            end else begin
                s2_res   <= simd_add(s1_psum, s1_prod, s1_tag);
                s2_valid <= s1_valid;
            end
        end
    end

    assign weight_out = shadow_w;
    assign res_mac_n  = s2_res;
    assign res_valid  = s2_valid;

    // Activation forward path: valid bit rides alongside the data word.
    logic [BIT_WIDTH:0] fwd [0:FWD_DEPTH];

    assign fwd[0] = {data_valid_in, data_input};

    generate
        for (genvar g = 0; g < FWD_DEPTH; g++) begin : g_fwd
            register #(.WIDTH(BIT_WIDTH + 1)) u_stage (
                .clk   (clk),
                .reset (reset),
                .ce    (ce),
                .sclr  (sclr),
                .d     (fwd[g]),
                .q     (fwd[g+1])
            );
        end
    endgenerate

    assign data_valid_next_row = fwd[FWD_DEPTH][BIT_WIDTH];
    assign data_input_next_row = fwd[FWD_DEPTH][BIT_WIDTH-1:0];

endmodule

// File: tb/tb_mxu_pe_simd.sv
// tb/tb_mxu_pe_simd.sv - directed self-checking bench for mxu_pe_simd
module tb_mxu_pe_simd;

    logic        clk;
    logic        reset;
    logic        ce;
    logic        sclr;
    logic [1:0]  data_type;
    logic        data_valid_in;
    logic [63:0] data_input;
    logic [63:0] res_mac_p;
    logic [63:0] weight_in;
    logic        weight_shift;
    logic        weight_swap;
    logic [63:0] weight_out;
    logic [63:0] res_mac_n;
    logic        res_valid;
    logic [63:0] data_input_next_row;
    logic        data_valid_next_row;

    int checks;
    int failures;

    mxu_pe_simd #(
        .BIT_WIDTH  (64),
        .FWD_DEPTH  (3),
        .USE_FABRIC ("NO")
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .ce                  (ce),
        .sclr                (sclr),
        .data_type           (data_type),
        .data_valid_in       (data_valid_in),
        .data_input          (data_input),
        .res_mac_p           (res_mac_p),
        .weight_in           (weight_in),
        .weight_shift        (weight_shift),
        .weight_swap         (weight_swap),
        .weight_out          (weight_out),
        .res_mac_n           (res_mac_n),
        .res_valid           (res_valid),
        .data_input_next_row (data_input_next_row),
        .data_valid_next_row (data_valid_next_row)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ce = 1'b1; sclr = 1'b0; data_type = 2'd3; data_valid_in = 1'b0;
        data_input = '0; res_mac_p = '0; weight_in = '0;
        weight_shift = 1'b0; weight_swap = 1'b0;
    endtask

    task automatic load_weight(input logic [63:0] w);
        weight_in = w; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0; weight_swap = 1'b1;
        tick();
        weight_swap = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) tick();
        checks++; if (res_mac_n !== 64'd0) begin failures++; $display("FAIL reset_res got=%h exp=0", res_mac_n); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", res_valid); end
        checks++; if (weight_out !== 64'd0) begin failures++; $display("FAIL reset_wout got=%h exp=0", weight_out); end
        checks++; if ({data_valid_next_row, data_input_next_row} !== 65'd0) begin failures++; $display("FAIL reset_fwd got=%h exp=0", data_input_next_row); end
        #2 reset = 1'b1;
        tick();
    endtask

    task automatic test_weight_chain();
        weight_in = 64'h11; weight_shift = 1'b1;
        tick();
        checks++; if (weight_out !== 64'h11) begin failures++; $display("FAIL chain_wout1 got=%h exp=11", weight_out); end
        weight_in = 64'h22;
        tick();
        checks++; if (weight_out !== 64'h22) begin failures++; $display("FAIL chain_wout2 got=%h exp=22", weight_out); end
        weight_shift = 1'b0; weight_swap = 1'b1;
        tick();
        weight_swap = 1'b0;
        data_type = 2'd3; data_input = 64'd1; res_mac_p = 64'd0; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'h22) begin failures++; $display("FAIL chain_res got=%h exp=22", res_mac_n); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL chain_valid got=%b exp=1", res_valid); end
    endtask

    task automatic test_lanes8();
        load_weight(64'hFEFE_FEFE_FEFE_FEFE);
        data_type = 2'd0; data_input = 64'h0303_0303_0303_0303;
        res_mac_p = 64'h0A0A_0A0A_0A0A_0A0A; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'h0404_0404_0404_0404) begin failures++; $display("FAIL lanes8_res got=%h exp=0404040404040404", res_mac_n); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL lanes8_valid got=%b exp=1", res_valid); end
    endtask

    task automatic test_wrap_isolation();
        load_weight(64'h0002_0002_0002_0002);
        data_type = 2'd1; data_input = 64'h0000_0000_7FFF_0000;
        res_mac_p = 64'h1111_2222_0003_4444; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'h1111_2222_0001_4444) begin failures++; $display("FAIL wrap16_res got=%h exp=1111222200014444", res_mac_n); end
    endtask

    task automatic test_back_to_back();
        load_weight(64'd7);
        weight_in = 64'h0000_0004_0000_0004; weight_shift = 1'b1;
        tick();
        weight_shift = 1'b0;
        data_type = 2'd3; data_input = 64'd5; res_mac_p = 64'd1;
        data_valid_in = 1'b1; weight_swap = 1'b1;
        tick();
        weight_swap = 1'b0;
        data_type = 2'd2; data_input = 64'hFFFF_FFFF_FFFF_FFFF; res_mac_p = 64'd0;
        tick();
        checks++; if (res_mac_n !== 64'd36) begin failures++; $display("FAIL b2b_op64 got=%h exp=24", res_mac_n); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid64 got=%b exp=1", res_valid); end
        data_valid_in = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'hFFFF_FFFC_FFFF_FFFC) begin failures++; $display("FAIL b2b_op32 got=%h exp=FFFFFFFCFFFFFFFC", res_mac_n); end
        checks++; if (res_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid32 got=%b exp=1", res_valid); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL b2b_invalid got=%b exp=0", res_valid); end
    endtask

    task automatic test_shift_swap();
        weight_in = 64'hAA; weight_shift = 1'b1;
        tick();
        weight_in = 64'hBB; weight_swap = 1'b1;
        tick();
        weight_shift = 1'b0; weight_swap = 1'b0;
        checks++; if (weight_out !== 64'hBB) begin failures++; $display("FAIL ss_shadow got=%h exp=BB", weight_out); end
        data_type = 2'd3; data_input = 64'd1; res_mac_p = 64'd0; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'hAA) begin failures++; $display("FAIL ss_active got=%h exp=AA", res_mac_n); end
    endtask

    task automatic test_sclr();
        data_type = 2'd3; data_input = 64'd9; res_mac_p = 64'd9; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0; sclr = 1'b1;
        tick();
        sclr = 1'b0;
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL sclr_valid got=%b exp=0", res_valid); end
        checks++; if (weight_out !== 64'd0) begin failures++; $display("FAIL sclr_wout got=%h exp=0", weight_out); end
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL sclr_drain got=%b exp=0", res_valid); end
    endtask

    task automatic test_stall();
        load_weight(64'd3);
        repeat (3) tick();
        data_type = 2'd3; data_input = 64'd2; res_mac_p = 64'd5; data_valid_in = 1'b1;
        tick();
        data_valid_in = 1'b0; data_input = '0; res_mac_p = '0;
        ce = 1'b0; sclr = 1'b1;
        repeat (4) tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL stall_hold_valid got=%b exp=0", res_valid); end
        checks++; if (data_valid_next_row !== 1'b0) begin failures++; $display("FAIL stall_hold_fwd got=%b exp=0", data_valid_next_row); end
        ce = 1'b1; sclr = 1'b0;
        tick();
        checks++; if (res_mac_n !== 64'd11 || res_valid !== 1'b1) begin failures++; $display("FAIL stall_res got=%h/%b exp=b/1", res_mac_n, res_valid); end
        checks++; if (data_valid_next_row !== 1'b0) begin failures++; $display("FAIL stall_fwd_early got=%b exp=0", data_valid_next_row); end
        tick();
        checks++; if (data_input_next_row !== 64'd2 || data_valid_next_row !== 1'b1) begin failures++; $display("FAIL stall_fwd got=%h/%b exp=2/1", data_input_next_row, data_valid_next_row); end
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL stall_no_dup got=%b exp=0", res_valid); end
        tick();
        checks++; if (data_valid_next_row !== 1'b0) begin failures++; $display("FAIL stall_fwd_after got=%b exp=0", data_valid_next_row); end
    endtask

    task automatic test_mid_reset();
        load_weight(64'h55);
        data_type = 2'd3; data_input = 64'd1; res_mac_p = 64'd1; data_valid_in = 1'b1;
        tick();
        tick();
        #2 reset = 1'b0;
        #1;
        checks++; if (res_mac_n !== 64'd0 || res_valid !== 1'b0) begin failures++; $display("FAIL mreset_res got=%h/%b exp=0/0", res_mac_n, res_valid); end
        checks++; if (weight_out !== 64'd0) begin failures++; $display("FAIL mreset_wout got=%h exp=0", weight_out); end
        checks++; if (data_input_next_row !== 64'd0 || data_valid_next_row !== 1'b0) begin failures++; $display("FAIL mreset_fwd got=%h/%b exp=0/0", data_input_next_row, data_valid_next_row); end
        data_valid_in = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin failures++; $display("FAIL mreset_after got=%b exp=0", res_valid); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_weight_chain();
        test_lanes8();
        test_wrap_isolation();
        test_back_to_back();
        test_shift_swap();
        test_sclr();
        test_stall();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
